// File: rtl/dw_data_sync_mc_if.sv
// Bus bundle for the multi-channel filtered data synchronizer: source buses in,
// filtered buses, new-data flags and skew monitors out.
interface dw_data_sync_mc_if #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 2,
   parameter int FILT_SIZE = 2
);
   logic [CHANNELS*WIDTH-1:0]         data_s;
   logic [FILT_SIZE-1:0]              filt_d;
   logic [CHANNELS-1:0]               data_avail_d;
   logic [CHANNELS*WIDTH-1:0]         data_d;
   logic [CHANNELS*(FILT_SIZE+1)-1:0] max_skew_d;

   modport master (
      output data_s,
      output filt_d,
      input  data_avail_d,
      input  data_d,
      input  max_skew_d
   );

   modport slave (
      input  data_s,
      input  filt_d,
      output data_avail_d,
      output data_d,
      output max_skew_d
   );
endinterface

// File: rtl/dw_data_sync_mc.sv
// Multi-channel data-bus synchronizer with per-channel stability filter,
// new-data indication (pulse or toggle) and maximum settling-skew monitor.
module dw_data_sync_mc #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 2,
   parameter int F_SYNC_TYPE = 2,
   parameter int FILT_SIZE   = 2,
   parameter int AVAIL_MODE  = 0
) (
   input logic                  clk_d,
   input logic                  rst_d,
   input logic                  init_d,
   input logic                  clr_skew_d,
   input logic                  test,
   dw_data_sync_mc_if.slave     bus
);
   localparam int CW = FILT_SIZE + 1;
   localparam int BW = CHANNELS * WIDTH;
   localparam logic [CW-1:0] SAT = '1;
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [BW-1:0] s;
   logic [CHANNELS-1:0][WIDTH-1:0] s_ch;

   // Synchronizer stages keep shifting during soft init; test mode taps stage 0.
   generate
      if (F_SYNC_TYPE == 0) begin : g_nosync
         assign s = bus.data_s;
      end else begin : g_sync
         logic [BW-1:0] sync_q [F_SYNC_TYPE];
         logic [BW-1:0] sync_d [F_SYNC_TYPE];

         always_comb begin
            sync_d[0] = bus.data_s;
            for (int i = 1; i < F_SYNC_TYPE; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         always_ff @(posedge clk_d) begin
            if (rst_d) begin
               for (int i = 0; i < F_SYNC_TYPE; i++) begin
                  sync_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < F_SYNC_TYPE; i++) begin
                  sync_q[i] <= sync_d[i];
               end
            end
         end

         assign s = test ? sync_q[0] : sync_q[F_SYNC_TYPE-1];
      end
   endgenerate

   assign s_ch = s;

   logic [CHANNELS-1:0][WIDTH-1:0] prev_q, prev_d;
   logic [CHANNELS-1:0][WIDTH-1:0] dout_q, dout_d;
   logic [CHANNELS-1:0][CW-1:0]    st_q, st_d;
   logic [CHANNELS-1:0][CW-1:0]    sk_q, sk_d;
   logic [CHANNELS-1:0][CW-1:0]    mskew_q, mskew_d;
   logic [CHANNELS-1:0]            avail_q, avail_d;

   always_comb begin : p_next
      logic          changed;
      logic          stable;
      logic          accept;
      logic [CW-1:0] st_nx;
      logic [CW-1:0] sk_nx;
      changed = 1'b0;
      stable  = 1'b0;
      accept  = 1'b0;
      st_nx   = '0;
      sk_nx   = '0;
      prev_d  = prev_q;
      dout_d  = dout_q;
      st_d    = st_q;
      sk_d    = sk_q;
      mskew_d = mskew_q;
      avail_d = avail_q;
      for (int c = 0; c < CHANNELS; c++) begin
         changed = (s_ch[c] != prev_q[c]);
         st_nx   = changed ? '0 : ((st_q[c] == SAT) ? SAT : st_q[c] + ONE);
         sk_nx   = !changed ? sk_q[c] : ((sk_q[c] == SAT) ? SAT : sk_q[c] + ONE);
         stable  = (st_nx >= {1'b0, bus.filt_d});
         accept  = stable && (s_ch[c] != dout_q[c]);

         prev_d[c]  = s_ch[c];
         st_d[c]    = st_nx;
         sk_d[c]    = sk_nx;
         mskew_d[c] = clr_skew_d ? '0 : mskew_q[c];
         avail_d[c] = (AVAIL_MODE != 0) ? avail_q[c] : 1'b0;

         // A clear coinciding with an accept still records this update's skew.
         if (accept) begin
            dout_d[c] = s_ch[c];
            sk_d[c]   = '0;
            if (clr_skew_d || (sk_nx > mskew_q[c])) begin
               mskew_d[c] = sk_nx;
            end
            avail_d[c] = (AVAIL_MODE != 0) ? ~avail_q[c] : 1'b1;
         end else if (stable) begin
            sk_d[c] = '0;
         end
      end
   end

   always_ff @(posedge clk_d) begin
      if (rst_d || init_d) begin
         prev_q  <= '0;
         dout_q  <= '0;
         st_q    <= '0;
         sk_q    <= '0;
         mskew_q <= '0;
         avail_q <= '0;
      end else begin
         prev_q  <= prev_d;
         dout_q  <= dout_d;
         st_q    <= st_d;
         sk_q    <= sk_d;
         mskew_q <= mskew_d;
         avail_q <= avail_d;
      end
   end

   assign bus.data_d       = dout_q;
   assign bus.max_skew_d   = mskew_q;
   assign bus.data_avail_d = avail_q;
endmodule

// File: tb/tb_dw_data_sync_mc.sv
// Directed bench for dw_data_sync_mc: pulse-mode unit, toggle-mode unit and a
// three-stage unit exercised in test mode.
module tb_dw_data_sync_mc;
   logic clk_d = 1'b0;
   logic rst_d;
   logic init_d;
   logic clr_skew_d;
   logic test_ab;
   logic test_c;

   int n_cmp = 0;
   int n_err = 0;
   int avail_cnt = 0;

   always #5 clk_d = ~clk_d;

   dw_data_sync_mc_if #(.WIDTH(8), .CHANNELS(2), .FILT_SIZE(2)) ifa ();
   dw_data_sync_mc_if #(.WIDTH(8), .CHANNELS(2), .FILT_SIZE(2)) ifb ();
   dw_data_sync_mc_if #(.WIDTH(8), .CHANNELS(2), .FILT_SIZE(2)) ifc ();

   dw_data_sync_mc #(.WIDTH(8), .CHANNELS(2), .F_SYNC_TYPE(2), .FILT_SIZE(2), .AVAIL_MODE(0)) u_a (
      .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .clr_skew_d(clr_skew_d), .test(test_ab), .bus(ifa));
   dw_data_sync_mc #(.WIDTH(8), .CHANNELS(2), .F_SYNC_TYPE(2), .FILT_SIZE(2), .AVAIL_MODE(1)) u_b (
      .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .clr_skew_d(clr_skew_d), .test(test_ab), .bus(ifb));
   dw_data_sync_mc #(.WIDTH(8), .CHANNELS(2), .F_SYNC_TYPE(3), .FILT_SIZE(2), .AVAIL_MODE(0)) u_c (
      .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .clr_skew_d(clr_skew_d), .test(test_c), .bus(ifc));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advances n edges, sampling 1 time unit after each; counts ch0 avail of unit A.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_d);
         #1;
         if (ifa.data_avail_d[0] === 1'b1) avail_cnt++;
      end
   endtask

   task automatic applyStimulus(input logic [15:0] ds, input int cycles);
      ifa.data_s = ds;
      tick(cycles);
   endtask

   initial begin
      logic [7:0] v;
      rst_d = 1'b1;  init_d = 1'b0;  clr_skew_d = 1'b0;
      test_ab = 1'b0;  test_c = 1'b0;
      ifa.data_s = 16'hFFFF;  ifa.filt_d = 2'd2;
      ifb.data_s = 16'h0000;  ifb.filt_d = 2'd1;
      ifc.data_s = 16'h0000;  ifc.filt_d = 2'd0;

      tick(2);
      checkOutput("rst_data",  ifa.data_d, 16'h0000);
      checkOutput("rst_avail", ifa.data_avail_d, 2'b00);
      checkOutput("rst_skew",  ifa.max_skew_d, 6'h00);

      rst_d = 1'b0;
      tick(4);
      checkOutput("rel_early", ifa.data_d, 16'h0000);
      tick(1);
      checkOutput("rel_data",  ifa.data_d, 16'hFFFF);
      checkOutput("rel_avail", ifa.data_avail_d, 2'b11);
      checkOutput("rel_skew",  ifa.max_skew_d, 6'h09);

      tick(2);
      init_d = 1'b1;
      tick(1);
      init_d = 1'b0;
      checkOutput("init_data",  ifa.data_d, 16'h0000);
      checkOutput("init_avail", ifa.data_avail_d, 2'b00);
      checkOutput("init_skew",  ifa.max_skew_d, 6'h00);
      tick(2);
      checkOutput("init_sync_early", ifa.data_d, 16'h0000);
      tick(1);
      checkOutput("init_sync_kept", ifa.data_d, 16'hFFFF);

      applyStimulus(16'hFF00, 8);
      clr_skew_d = 1'b1;
      tick(1);
      clr_skew_d = 1'b0;
      checkOutput("clr_alone", ifa.max_skew_d, 6'h00);

      applyStimulus(16'hFF5A, 4);
      checkOutput("lat_early_data",  ifa.data_d, 16'hFF00);
      checkOutput("lat_early_avail", ifa.data_avail_d, 2'b00);
      tick(1);
      checkOutput("lat_data",  ifa.data_d, 16'hFF5A);
      checkOutput("lat_avail", ifa.data_avail_d, 2'b01);
      checkOutput("lat_skew",  ifa.max_skew_d, 6'h01);
      tick(1);
      checkOutput("lat_pulse_end", ifa.data_avail_d, 2'b00);

      avail_cnt = 0;
      applyStimulus(16'hFF0F, 1);
      applyStimulus(16'hFFFF, 8);
      checkOutput("skew_data",  ifa.data_d, 16'hFFFF);
      checkOutput("skew_nupd",  avail_cnt, 1);
      checkOutput("skew_max",   ifa.max_skew_d, 6'h02);

      avail_cnt = 0;
      applyStimulus(16'hFF00, 1);
      applyStimulus(16'hFFFF, 8);
      checkOutput("glitch_data", ifa.data_d, 16'hFFFF);
      checkOutput("glitch_nupd", avail_cnt, 0);
      checkOutput("glitch_max",  ifa.max_skew_d, 6'h02);

      applyStimulus(16'hFFA5, 4);
      clr_skew_d = 1'b1;
      tick(1);
      clr_skew_d = 1'b0;
      checkOutput("clr_acc_data", ifa.data_d, 16'hFFA5);
      checkOutput("clr_acc_skew", ifa.max_skew_d, 6'h01);

      ifa.filt_d = 2'd0;
      tick(2);
      for (int i = 0; i < 10; i++) begin
         v = (i % 2 == 0) ? 8'h55 : 8'hAA;
         applyStimulus({8'hFF, v}, 1);
         if (i >= 2) begin
            checkOutput("f0_follow", ifa.data_d[7:0], v);
            checkOutput("f0_avail",  ifa.data_avail_d[0], 1'b1);
         end
      end
      tick(5);
      checkOutput("f0_final", ifa.data_d, 16'hFFAA);

      ifa.filt_d = 2'd3;
      avail_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         v = (i % 2 == 0) ? 8'h55 : 8'hAA;
         applyStimulus({8'hFF, v}, 1);
      end
      checkOutput("f3_hold_data", ifa.data_d, 16'hFFAA);
      checkOutput("f3_hold_nupd", avail_cnt, 0);
      tick(5);
      checkOutput("f3_acc_data", ifa.data_d, 16'hFF55);
      checkOutput("f3_sat_skew", ifa.max_skew_d, 6'h07);
      checkOutput("f3_acc_nupd", avail_cnt, 1);

      checkOutput("tog_start", ifb.data_avail_d, 2'b00);
      for (int k = 0; k < 3; k++) begin
         ifb.data_s = {8'(8'h11 * (k + 1)), 8'h00};
         tick(12);
         checkOutput("tog_data",  ifb.data_d[15:8], 8'(8'h11 * (k + 1)));
         checkOutput("tog_avail", ifb.data_avail_d, (k % 2 == 0) ? 2'b10 : 2'b00);
      end

      test_c = 1'b1;
      tick(4);
      ifc.data_s = 16'h003C;
      tick(1);
      checkOutput("test_early", ifc.data_d, 16'h0000);
      tick(1);
      checkOutput("test_data",  ifc.data_d, 16'h003C);
      checkOutput("test_avail", ifc.data_avail_d, 2'b01);
      test_c = 1'b0;
      tick(4);
      ifc.data_s = 16'h00C3;
      tick(3);
      checkOutput("sync3_early", ifc.data_d, 16'h003C);
      tick(1);
      checkOutput("sync3_data",  ifc.data_d, 16'h00C3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dw_data_sync_mc.md
Name: dw_data_sync_mc

Overview:
Multi-channel, filtered data-bus synchronizer: CHANNELS independent buses enter through a configurable synchronizer chain. Each bus goes through a programmable stability filter, then a registered output with a new-data indicator and per-channel skew monitor. It generalises the single-channel data sync with per-channel operation, a selectable availability mode (pulse/toggle), skew-monitor clear and a soft init. It sits at the receiving-domain boundary of multi-bit, slowly changing control/status buses.

Parameters:
WIDTH, 8, bits per channel (1..1024)
CHANNELS, 2, number of independent channels (1..16)
F_SYNC_TYPE, 2, synchronizer register stages on data_s (0..4; 0 = no sync stage, s = data_s)
FILT_SIZE, 2, width of filt_d (1..8); skew counters are FILT_SIZE+1 bits
AVAIL_MODE, 0, 0 = data_avail_d one-cycle pulse, 1 = data_avail_d toggles per update

Ports:
clk_d  input  1  destination clock; all state on rising edge
rst_d  input  1  synchronous active-high reset
init_d  input  1  synchronous active-high soft init (all state except synchronizer stages)
data_s  input  CHANNELS*WIDTH  source buses; channel c = bits [c*WIDTH +: WIDTH]
filt_d  input  FILT_SIZE  stability filter length in cycles (shared by all channels)
clr_skew_d  input  1  synchronous clear of all max_skew_d fields
test  input  1  1 = synchronizer chain collapsed to a single register stage (scan/test)
data_avail_d  output  CHANNELS  per-channel new-data indicator
data_d  output  CHANNELS*WIDTH  filtered, registered output buses
max_skew_d  output  CHANNELS*(FILT_SIZE+1)  per-channel maximum observed settling skew

Behaviour:
- Reset (rst_d=1 at edge): all synchronizer stages, prev, st, sk, data_d, data_avail_d, max_skew_d <= 0.
- Priority: rst_d > init_d > normal operation. init_d clears the same state as reset except synchronizer stages.
- Synchronizer: s_c = data_s_c delayed F_SYNC_TYPE edges. When test=1 and F_SYNC_TYPE>0, exactly one stage (s = data_s after 1 edge). F_SYNC_TYPE=0 ignores test.
- Per channel, each cycle:
  - prev <= s.
  - st (stable count, FILT_SIZE+1 bits, saturating): st_next = 0 if s != prev, else sat(st+1); st <= st_next.
  - sk (skew count, FILT_SIZE+1 bits, saturating): increments when s != prev.
  - accept = (st_next >= filt_d) && (s != data_d).
  - On accept: data_d <= s; max_skew_d <= max(max_skew_d, sk_next); sk <= 0.
  - Settle-back: if s == data_d and st_next >= filt_d (glitch returned to old value), sk <= 0 with no update and no avail.
- data_avail_d:
  - AVAIL_MODE=0: high for exactly the cycle after each accept edge, else 0.
  - AVAIL_MODE=1: inverts on each accept edge.
- Latency: single clean change of data_s → data_d update at edge F_SYNC_TYPE+1+filt_d after the sampling edge (test=1: 2+filt_d).
- filt_d=0: accept on the first cycle s differs from data_d; no filtering.
- Any change of s during filtering restarts st; data_d never takes an intermediate value held fewer than filt_d cycles past its change.
- Saturation: st and sk saturate at 2^(FILT_SIZE+1)-1, no wrap.
- clr_skew_d: all max_skew_d <= 0. If an accept occurs in the same cycle, that channel's max_skew_d <= sk_next (clear then update).
- filt_d changing mid-filter takes effect immediately against the current st.
- Channels are fully independent; no cross-channel coherency is implied.

Test Plan:
- Reset: assert rst_d 2 cycles with data_s=all ones → data_d=0, data_avail_d=0, max_skew_d=0. Same with init_d → identical, and synchronizer contents preserved.
- Latency: F_SYNC_TYPE=2, filt_d=2, ch0 data_s 0x00→0x5A at edge 0 → data_d[7:0]=0x5A after edge 5; data_avail_d[0] pulses one cycle; max_skew_d[0]=1; ch1 unchanged, no avail.
- Skew/glitch: ch0 0x00→0x0F→0xFF on consecutive cycles, filt_d=2 → single update to 0xFF, max_skew_d[0]=2. Then a 1-cycle glitch 0xFF→0x00→0xFF → no update, no avail, max_skew_d[0] stays 2.
- filt_d=0 and saturation: filt_d=0, toggle ch0 every cycle for 10 cycles → data_d follows each value one cycle behind s, avail high every cycle. Then filt_d=3 (FILT_SIZE=2), toggle 10 cycles → no update, and sk saturates at 7, giving max_skew_d=7 at the next accept.
- AVAIL_MODE=1: three separated updates on ch1 → data_avail_d[1] sequence 0→1→0→1, one transition per accept.
- clr_skew_d: max_skew_d[0]=2, then clr_skew_d in the same cycle as an accept with sk=1 → max_skew_d[0]=1. clr_skew_d alone → 0. test=1, F_SYNC_TYPE=3, filt_d=0 → latency 2 cycles.
